// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with a stallable memory
// handshake, illegal-opcode trap, memory watchdog and retired-instruction counter.
module multicycle_controller #(
    parameter int MEM_TIMEOUT     = 255,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       Opcode,
    input  logic             mem_ready,
    output logic             InstrFetch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             Branch,
    output logic             Jal,
    output logic             Jalr,
    output logic [1:0]       ALUOp,
    output logic             Retire,
    output logic             Halt,
    output logic             Illegal,
    output logic             MemFault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    localparam int WC_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t            state_reg;
    logic [6:0]        opcode_q;
    logic [WC_W-1:0]   wait_cnt;
    logic              mem_fault_reg;
    logic [CNT_W-1:0]  retired_reg;

    logic       timeout;
    logic       instr_fetch_dec, mem_read_dec, mem_write_dec, ir_write_dec, pc_write_dec;
    logic       alu_src_dec, mem_to_reg_dec, reg_write_dec, branch_dec, jal_dec, jalr_dec;
    logic [1:0] alu_op_dec;
    logic       retire_dec, halt_dec, illegal_dec, mem_fault_dec;

    function automatic logic is_known(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR};
    endfunction

    // The pending request has waited MEM_TIMEOUT-1 cycles and this one is not ready either.
    assign timeout = (MEM_TIMEOUT != 0) && !mem_ready
                  && ((32'(wait_cnt) + 32'd1) == 32'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_FETCH;
            opcode_q      <= '0;
            wait_cnt      <= '0;
            mem_fault_reg <= 1'b0;
            retired_reg   <= '0;
        end else begin
            wait_cnt <= '0;
            if (retire_dec)
                retired_reg <= retired_reg + CNT_W'(1);
            case (state_reg)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_reg <= S_DECODE;
                    end else if (timeout) begin
                        state_reg     <= S_TRAP;
                        mem_fault_reg <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_DECODE: begin
                    opcode_q <= Opcode;
                    if (Opcode == OP_HALT) begin
                        state_reg <= S_HALTED;
                    end else if (is_known(Opcode)) begin
                        state_reg <= S_EXEC;
                    end else if (TRAP_ON_ILLEGAL) begin
                        state_reg     <= S_TRAP;
                        mem_fault_reg <= 1'b0;
                    end else begin
                        state_reg <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_BEQ:       state_reg <= S_FETCH;
                        OP_LW, OP_SW: state_reg <= S_MEM;
                        default:      state_reg <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_reg <= (opcode_q == OP_LW) ? S_WB : S_FETCH;
                    end else if (timeout) begin
                        state_reg     <= S_TRAP;
                        mem_fault_reg <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_WB:    state_reg <= S_FETCH;
                default: state_reg <= state_reg;
            endcase
        end
    end

    always_comb begin
        instr_fetch_dec = 1'b0;
        mem_read_dec    = 1'b0;
        mem_write_dec   = 1'b0;
        ir_write_dec    = 1'b0;
        pc_write_dec    = 1'b0;
        alu_src_dec     = 1'b0;
        mem_to_reg_dec  = 1'b0;
        reg_write_dec   = 1'b0;
        branch_dec      = 1'b0;
        jal_dec         = 1'b0;
        jalr_dec        = 1'b0;
        alu_op_dec      = 2'b00;
        retire_dec      = 1'b0;
        halt_dec        = 1'b0;
        illegal_dec     = 1'b0;
        mem_fault_dec   = 1'b0;

        // ALU operand selection stays valid through MEM so the address is stable.
        if (state_reg == S_EXEC || state_reg == S_MEM) begin
            alu_src_dec = opcode_q inside {OP_I, OP_LW, OP_SW, OP_JALR};
            case (opcode_q)
                OP_BEQ:       alu_op_dec = 2'b01;
                OP_R, OP_I:   alu_op_dec = 2'b10;
                OP_JALR:      alu_op_dec = 2'b11;
                default:      alu_op_dec = 2'b00;
            endcase
        end

        case (state_reg)
            S_FETCH: begin
                instr_fetch_dec = 1'b1;
                mem_read_dec    = 1'b1;
                ir_write_dec    = mem_ready;
                pc_write_dec    = mem_ready;
            end
            S_DECODE: begin
                retire_dec = !TRAP_ON_ILLEGAL && (Opcode != OP_HALT) && !is_known(Opcode);
            end
            S_EXEC: begin
                branch_dec = (opcode_q == OP_BEQ);
                jal_dec    = (opcode_q == OP_JAL);
                jalr_dec   = (opcode_q == OP_JALR);
                retire_dec = (opcode_q == OP_BEQ);
            end
            S_MEM: begin
                mem_read_dec  = (opcode_q == OP_LW);
                mem_write_dec = (opcode_q == OP_SW);
                retire_dec    = (opcode_q == OP_SW) && mem_ready;
            end
            S_WB: begin
                reg_write_dec  = 1'b1;
                mem_to_reg_dec = (opcode_q == OP_LW);
                retire_dec     = 1'b1;
            end
            S_HALTED: halt_dec = 1'b1;
            S_TRAP: begin
                illegal_dec   = !mem_fault_reg;
                mem_fault_dec = mem_fault_reg;
            end
            default: ;
        endcase
    end

    // Everything reads as zero while reset is held, including an in-flight store.
    assign InstrFetch = rst_n & instr_fetch_dec;
    assign MemRead    = rst_n & mem_read_dec;
    assign MemWrite   = rst_n & mem_write_dec;
    assign IRWrite    = rst_n & ir_write_dec;
    assign PCWrite    = rst_n & pc_write_dec;
    assign ALUSrc     = rst_n & alu_src_dec;
    assign MemtoReg   = rst_n & mem_to_reg_dec;
    assign RegWrite   = rst_n & reg_write_dec;
    assign Branch     = rst_n & branch_dec;
    assign Jal        = rst_n & jal_dec;
    assign Jalr       = rst_n & jalr_dec;
    assign ALUOp      = rst_n ? alu_op_dec : 2'b00;
    assign Retire     = rst_n & retire_dec;
    assign Halt       = rst_n & halt_dec;
    assign Illegal    = rst_n & illegal_dec;
    assign MemFault   = rst_n & mem_fault_dec;
    assign state      = rst_n ? state_reg : 3'd0;
    assign retired    = rst_n ? retired_reg : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its expected phase
// sequence, then driven cycle by cycle with outputs checked against that plan.
module tb_multicycle_controller;
    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB = 3'd4, ST_HALTED = 3'd5, ST_TRAP = 3'd6;
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_JAL = 5, C_JALR = 6;
    localparam int C_HALT = 7, C_ILL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    // Packed controls: {InstrFetch,MemRead,MemWrite,IRWrite,PCWrite,ALUSrc,MemtoReg,
    //                   RegWrite,Branch,Jal,Jalr,ALUOp[1:0],Retire,Halt,Illegal,MemFault}
    wire [16:0] a_ctl, b_ctl;
    wire [2:0]  a_state, b_state;
    wire [3:0]  a_ret;
    wire [31:0] b_ret;

    multicycle_controller #(.MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
        .InstrFetch(a_ctl[16]), .MemRead(a_ctl[15]), .MemWrite(a_ctl[14]), .IRWrite(a_ctl[13]),
        .PCWrite(a_ctl[12]), .ALUSrc(a_ctl[11]), .MemtoReg(a_ctl[10]), .RegWrite(a_ctl[9]),
        .Branch(a_ctl[8]), .Jal(a_ctl[7]), .Jalr(a_ctl[6]), .ALUOp(a_ctl[5:4]),
        .Retire(a_ctl[3]), .Halt(a_ctl[2]), .Illegal(a_ctl[1]), .MemFault(a_ctl[0]),
        .state(a_state), .retired(a_ret)
    );

    multicycle_controller #(.MEM_TIMEOUT(255), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
        .InstrFetch(b_ctl[16]), .MemRead(b_ctl[15]), .MemWrite(b_ctl[14]), .IRWrite(b_ctl[13]),
        .PCWrite(b_ctl[12]), .ALUSrc(b_ctl[11]), .MemtoReg(b_ctl[10]), .RegWrite(b_ctl[9]),
        .Branch(b_ctl[8]), .Jal(b_ctl[7]), .Jalr(b_ctl[6]), .ALUOp(b_ctl[5:4]),
        .Retire(b_ctl[3]), .Halt(b_ctl[2]), .Illegal(b_ctl[1]), .MemFault(b_ctl[0]),
        .state(b_state), .retired(b_ret)
    );

    wire [16:0] obs_ctl   = sel ? b_ctl : a_ctl;
    wire [2:0]  obs_state = sel ? b_state : a_state;
    wire [31:0] obs_ret   = sel ? b_ret : {28'd0, a_ret};

    // Model configuration mirrors whichever instance is selected.
    int m_tmo = 4;
    bit m_trap = 1'b1;
    int m_cnt_w = 4;
    int unsigned model_ret = 0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0] st;
        int         rdy;   // 0 / 1 forced, 2 = random (must be ignored)
        bit         ret;
    } step_t;
    step_t plan[$];
    int plan_cause;        // 1 illegal, 2 memory fault

    logic [6:0] ill_ops [4] = '{7'b0001111, 7'b0000000, 7'b1110011, 7'b0110111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want,
                       input logic [31:0] msk);
        vectors++;
        assert ((got & msk) === (want & msk)) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h (mask %h)", tag, got, want, msk);
        end
    endtask

    function automatic logic [31:0] ret_mask();
        return (m_cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << m_cnt_w) - 32'd1);
    endfunction

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_BEQ:   return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_HALT:  return 7'b1111111;
            default: return ill_ops[$urandom_range(0, 3)];
        endcase
    endfunction

    task automatic add(input logic [2:0] st, input int rdy, input bit ret);
        step_t s;
        s.st = st; s.rdy = rdy; s.ret = ret;
        plan.push_back(s);
    endtask

    // Expand one instruction into its cycle-by-cycle phases.
    task automatic build(input int cls, input int fw, input int mw, input int tail);
        plan.delete();
        plan_cause = 0;
        if (m_tmo != 0 && fw >= m_tmo) begin
            repeat (m_tmo) add(ST_FETCH, 0, 0);
            repeat (tail) add(ST_TRAP, 2, 0);
            plan_cause = 2;
            return;
        end
        repeat (fw) add(ST_FETCH, 0, 0);
        add(ST_FETCH, 1, 0);
        if (cls == C_HALT) begin
            add(ST_DECODE, 2, 0);
            repeat (tail) add(ST_HALTED, 2, 0);
        end else if (cls == C_ILL) begin
            if (m_trap) begin
                add(ST_DECODE, 2, 0);
                repeat (tail) add(ST_TRAP, 2, 0);
                plan_cause = 1;
            end else begin
                add(ST_DECODE, 2, 1);
            end
        end else begin
            add(ST_DECODE, 2, 0);
            add(ST_EXEC, 2, cls == C_BEQ);
            if (cls == C_LW || cls == C_SW) begin
                if (m_tmo != 0 && mw >= m_tmo) begin
                    repeat (m_tmo) add(ST_MEM, 0, 0);
                    repeat (tail) add(ST_TRAP, 2, 0);
                    plan_cause = 2;
                end else begin
                    repeat (mw) add(ST_MEM, 0, 0);
                    add(ST_MEM, 1, cls == C_SW);
                    if (cls == C_LW) add(ST_WB, 2, 1);
                end
            end else if (cls != C_BEQ) begin
                add(ST_WB, 2, 1);
            end
        end
    endtask

    function automatic logic [16:0] exp_vec(input logic [2:0] st, input int cls, input bit rdy,
                                            input bit ret);
        logic [16:0] v;
        v = '0;
        v[16] = (st == ST_FETCH);
        v[15] = (st == ST_FETCH) || (st == ST_MEM && cls == C_LW);
        v[14] = (st == ST_MEM && cls == C_SW);
        v[13] = (st == ST_FETCH) && rdy;
        v[12] = (st == ST_FETCH) && rdy;
        if (st == ST_EXEC || st == ST_MEM) begin
            v[11] = cls inside {C_I, C_LW, C_SW, C_JALR};
            v[5:4] = (cls == C_BEQ) ? 2'b01 : (cls == C_R || cls == C_I) ? 2'b10 :
                     (cls == C_JALR) ? 2'b11 : 2'b00;
        end
        v[10] = (st == ST_WB && cls == C_LW);
        v[9]  = (st == ST_WB);
        v[8]  = (st == ST_EXEC && cls == C_BEQ);
        v[7]  = (st == ST_EXEC && cls == C_JAL);
        v[6]  = (st == ST_EXEC && cls == C_JALR);
        v[3]  = ret;
        v[2]  = (st == ST_HALTED);
        v[1]  = (st == ST_TRAP && plan_cause == 1);
        v[0]  = (st == ST_TRAP && plan_cause == 2);
        return v;
    endfunction

    function automatic logic [16:0] exp_mask(input logic [2:0] st, input int cls);
        logic [16:0] m;
        m = '1;
        if (!((st == ST_EXEC || st == ST_MEM) && cls != C_JAL)) begin
            m[11] = 1'b0;
            m[5:4] = 2'b00;
        end
        return m;
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_instr(input int cls, input int fw, input int mw, input int tail,
                             input int abort_at);
        logic [6:0] op;
        bit rdy;
        bit retires;
        int n;
        op = op_of(cls);
        build(cls, fw, mw, tail);
        n = (abort_at >= 0) ? abort_at : plan.size();
        retires = 1'b0;
        for (int k = 0; k < n; k++) begin
            Opcode    = (plan[k].st == ST_DECODE) ? op : 7'($urandom);
            rdy       = (plan[k].rdy == 2) ? 1'($urandom) : (plan[k].rdy != 0);
            mem_ready = rdy;
            #1;
            chk($sformatf("state c%0d s%0d", cls, k), {29'd0, obs_state}, {29'd0, plan[k].st},
                32'h7);
            chk($sformatf("ctl c%0d s%0d", cls, k), {15'd0, obs_ctl},
                {15'd0, exp_vec(plan[k].st, cls, rdy, plan[k].ret)},
                {15'd0, exp_mask(plan[k].st, cls)});
            if (plan[k].ret) retires = 1'b1;
            @(negedge clk);
        end
        if (abort_at < 0) begin
            if (retires) model_ret++;
            chk($sformatf("retired c%0d", cls), obs_ret, model_ret, ret_mask());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b1;
            Opcode    = 7'($urandom);
            #1;
            chk($sformatf("reset ctl %0d", k), {15'd0, obs_ctl}, 32'd0, 32'h1FFFF);
            chk($sformatf("reset state %0d", k), {29'd0, obs_state}, 32'd0, 32'h7);
            chk($sformatf("reset retired %0d", k), obs_ret, 32'd0, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        model_ret = 0;
        #1;
        chk("post-reset state", {29'd0, obs_state}, {29'd0, ST_FETCH}, 32'h7);
        chk("post-reset retired", obs_ret, 32'd0, 32'hFFFF_FFFF);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Directed basics on the trapping, 4-bit-counter instance
        run_instr(C_R, 0, 0, 0, -1);
        run_instr(C_LW, 0, 3, 0, -1);
        run_instr(C_BEQ, 0, 0, 0, -1);
        run_instr(C_SW, 1, 2, 0, -1);
        chk("retired after R,LW,BEQ,SW", obs_ret, 32'd4, 32'hF);
        for (int i = 0; i < 30; i++)
            run_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);

        // Counter wrap
        do_reset();
        repeat (17) run_instr(C_R, 0, 0, 0, -1);
        chk("wrap after 17", obs_ret, 32'd1, 32'hF);

        // Reset during the MEM phase of a store
        do_reset();
        run_instr(C_SW, 0, 2, 0, 4);
        do_reset();
        run_instr(C_R, 0, 0, 0, -1);

        // Watchdog boundary: fault on the 4th wait, ready on that cycle wins
        do_reset();
        run_instr(C_R, 4, 0, 6, -1);
        do_reset();
        run_instr(C_R, 3, 0, 0, -1);
        do_reset();
        run_instr(C_LW, 0, 4, 4, -1);
        do_reset();
        run_instr(C_SW, 0, 3, 0, -1);

        // Illegal opcode trap, then HALT held for 20 cycles
        do_reset();
        run_instr(C_ILL, 0, 0, 6, -1);
        do_reset();
        run_instr(C_R, 0, 0, 0, -1);
        run_instr(C_HALT, 1, 0, 20, -1);

        // Non-trapping, 32-bit-counter instance
        sel = 1'b1; m_tmo = 255; m_trap = 1'b0; m_cnt_w = 32;
        do_reset();
        run_instr(C_ILL, 0, 0, 0, -1);
        for (int i = 0; i < 25; i++) begin
            int r;
            r = $urandom_range(0, 7);
            run_instr((r == 7) ? C_ILL : r, $urandom_range(0, 8), $urandom_range(0, 8), 0, -1);
        end
        run_instr(C_HALT, 0, 0, 5, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
